// File: rtl/noc_egress_buffer.sv
// Tile-to-router egress buffer: a FIFO absorbs tile flit bursts, and the buffer
// forwards them under credit-based flow control with drop and credit-error status.
module noc_egress_buffer #(
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int DEPTH           = 8,
    parameter int CREDITS         = 4,
    localparam int FLIT_W = 2*$clog2(NODE_COUNT) + PACKET_ID_WIDTH + 20,
    localparam int OCC_W  = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    output logic              in_ready,
    output logic [FLIT_W-1:0] flit_out,
    input  logic              credit_in,
    output logic [OCC_W-1:0]  occupancy,
    output logic [7:0]        drop_count,
    output logic              credit_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CRED_W = $clog2(CREDITS+1);
    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(CREDITS);

    function automatic logic [7:0] satInc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    // The valid bit is implied by storage, so only the payload is kept.
    logic [FLIT_W-2:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [OCC_W-1:0]   occ;
    logic [CRED_W-1:0]  creditCnt;
    logic [FLIT_W-1:0]  flitOut_p1;
    logic [7:0]         dropCnt;
    logic               creditErr;
    logic               full;
    logic               push;
    logic               drop;
    logic               send;

    // Full is judged on registered occupancy, so a same-cycle send never frees a slot.
    assign full = (occ == FULL_OCC);
    assign push = flit_in[FLIT_W-1] & ~full;
    assign drop = flit_in[FLIT_W-1] & full;
    assign send = (occ != '0) && (creditCnt != '0);

    assign in_ready   = ~full;
    assign flit_out   = flitOut_p1;
    assign occupancy  = occ;
    assign drop_count = dropCnt;
    assign credit_err = creditErr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= flit_in[FLIT_W-2:0];
        end
    end

    // Stage p1: registered send towards the router
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            occ        <= '0;
            creditCnt  <= MAX_CRED;
            flitOut_p1 <= '0;
            dropCnt    <= '0;
            creditErr  <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (send) rdPtr <= rdPtr + PTR_W'(1);

            case ({push, send})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (credit_in && !send) begin
                if (creditCnt == MAX_CRED) creditErr <= 1'b1;
                else                       creditCnt <= creditCnt + CRED_W'(1);
            end else if (!credit_in && send) begin
                creditCnt <= creditCnt - CRED_W'(1);
            end

            if (drop) dropCnt <= satInc(dropCnt);

            flitOut_p1 <= send ? {1'b1, mem[rdPtr]} : '0;
        end
    end

endmodule

// File: tb/tb_noc_egress_buffer.sv
// Bench for noc_egress_buffer: a vector table for the first transactions and a
// queue scoreboard for fill, drop, credit, streaming and reset sequences.
module tb_noc_egress_buffer;

    localparam int NODE_COUNT      = 9;
    localparam int PACKET_ID_WIDTH = 5;
    localparam int DEPTH           = 8;
    localparam int CREDITS         = 4;
    localparam int FLIT_W = 2*$clog2(NODE_COUNT) + PACKET_ID_WIDTH + 20;
    localparam int OCC_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic              in_ready;
    logic [FLIT_W-1:0] flit_out;
    logic              credit_in = 1'b0;
    logic [OCC_W-1:0]  occupancy;
    logic [7:0]        drop_count;
    logic              credit_err;

    always #5 clk = ~clk;

    noc_egress_buffer #(
        .NODE_COUNT(NODE_COUNT),
        .PACKET_ID_WIDTH(PACKET_ID_WIDTH),
        .DEPTH(DEPTH),
        .CREDITS(CREDITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flit_in(flit_in),
        .in_ready(in_ready),
        .flit_out(flit_out),
        .credit_in(credit_in),
        .occupancy(occupancy),
        .drop_count(drop_count),
        .credit_err(credit_err)
    );

    typedef struct {
        logic              v;
        logic [FLIT_W-2:0] pay;
        logic              cr;
        logic [FLIT_W-1:0] expOut;
        int                expOcc;
    } vec_t;

    int                nChecks = 0;
    int                nFail = 0;
    logic [FLIT_W-2:0] sb[$];
    int                mCred = CREDITS;
    int                mDrop = 0;
    logic              mErr = 1'b0;
    logic              lastSend = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected send is popped from the scoreboard.
    task automatic step(input logic v, input logic [FLIT_W-2:0] pay, input logic cr);
        logic              full;
        logic              doPush;
        logic              doSend;
        logic [FLIT_W-1:0] expOut;
        flit_in   = {v, pay};
        credit_in = cr;
        full   = (sb.size() == DEPTH);
        doPush = v && !full;
        doSend = (sb.size() > 0) && (mCred > 0);
        expOut = '0;
        if (doSend) expOut = {1'b1, sb.pop_front()};
        if (doPush) sb.push_back(pay);
        if (v && full && mDrop < 255) mDrop++;
        if (cr && !doSend) begin
            if (mCred == CREDITS) mErr = 1'b1;
            else                  mCred++;
        end else if (!cr && doSend) begin
            mCred--;
        end
        lastSend = doSend;
        @(posedge clk);
        #1;
        check("flit_out", 64'(flit_out), 64'(expOut));
        check("occupancy", 64'(occupancy), 64'(sb.size()));
        check("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        check("drop_count", 64'(drop_count), 64'(mDrop));
        check("credit_err", 64'(credit_err), 64'(mErr));
    endtask

    // A valid flit is driven during reset to show it is not stored.
    task automatic resetDut(input logic [FLIT_W-2:0] pay);
        rst_n     = 1'b0;
        flit_in   = {1'b1, pay};
        credit_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        flit_in = '0;
        sb.delete();
        mCred = CREDITS;
        mDrop = 0;
        mErr  = 1'b0;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_flit_out", 64'(flit_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_credit_err", 64'(credit_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[11];
        int   s1;
        int   s2;
        int   t;
        int   sent;
        tbl[0]  = '{1'b1, 32'd1, 1'b0, 33'd0, 1};
        tbl[1]  = '{1'b1, 32'd2, 1'b0, {1'b1, 32'd1}, 1};
        tbl[2]  = '{1'b1, 32'd3, 1'b0, {1'b1, 32'd2}, 1};
        tbl[3]  = '{1'b0, 32'd0, 1'b0, {1'b1, 32'd3}, 0};
        tbl[4]  = '{1'b0, 32'd7, 1'b0, 33'd0, 0};
        tbl[5]  = '{1'b1, 32'd4, 1'b0, 33'd0, 1};
        tbl[6]  = '{1'b1, 32'd5, 1'b0, {1'b1, 32'd4}, 1};
        tbl[7]  = '{1'b0, 32'd0, 1'b0, 33'd0, 1};
        tbl[8]  = '{1'b0, 32'd0, 1'b0, 33'd0, 1};
        tbl[9]  = '{1'b0, 32'd0, 1'b1, 33'd0, 1};
        tbl[10] = '{1'b0, 32'd0, 1'b0, {1'b1, 32'd5}, 0};

        #2;
        resetDut(32'hDEAD);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].pay, tbl[i].cr);
            check("tbl_flit_out", 64'(flit_out), 64'(tbl[i].expOut));
            check("tbl_occupancy", 64'(occupancy), 64'(tbl[i].expOcc));
        end

        // Fill with no credits returned, then overflow and pop-while-full.
        resetDut(32'h0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h100 + i, 1'b0);
        check("fill_occupancy", 64'(occupancy), 64'd8);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_drop_count", 64'(drop_count), 64'd0);
        step(1'b1, 32'h1F0, 1'b0);
        step(1'b1, 32'h1F1, 1'b0);
        check("overflow_drop_count", 64'(drop_count), 64'd2);
        step(1'b0, 32'h0, 1'b1);
        check("credit_at_zero_no_send", 64'(flit_out), 64'd0);
        step(1'b1, 32'h1F2, 1'b0);
        check("full_pop_flit_out", 64'(flit_out), 64'({1'b1, 32'h104}));
        check("full_pop_occupancy", 64'(occupancy), 64'd7);
        check("full_pop_in_ready", 64'(in_ready), 64'd1);
        check("full_pop_drop_count", 64'(drop_count), 64'd3);
        step(1'b1, 32'h1F3, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 32'h400 + i, 1'b0);
        check("drop_saturation", 64'(drop_count), 64'd255);

        // Credit return at the maximum is legal when a send coincides.
        resetDut(32'h0);
        step(1'b1, 32'h200, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("credit_with_send_err", 64'(credit_err), 64'd0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("credit_overflow_err", 64'(credit_err), 64'd1);
        sent = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 6, 32'h210 + i, 1'b0);
            if (flit_out[FLIT_W-1]) sent++;
        end
        check("credit_max_sends", 64'(sent), 64'd4);
        check("credit_err_sticky", 64'(credit_err), 64'd1);

        // Streaming with credits returned two cycles after each send.
        resetDut(32'h0);
        s1 = 0;
        s2 = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h300 + i, s2[0]);
            s2 = s1;
            s1 = int'(lastSend);
        end
        t = 0;
        while ((sb.size() != 0 || s1 != 0 || s2 != 0) && t < 100) begin
            step(1'b0, 32'h0, s2[0]);
            s2 = s1;
            s1 = int'(lastSend);
            t++;
        end
        check("stream_drained", 64'(t < 100), 64'd1);
        check("stream_occupancy", 64'(occupancy), 64'd0);
        check("stream_drop_count", 64'(drop_count), 64'd0);

        // Reset with flits stored and credits consumed.
        for (int i = 0; i < 9; i++) step(1'b1, 32'h500 + i, 1'b0);
        check("pre_reset_occupancy", 64'(occupancy), 64'd5);
        resetDut(32'h555);
        step(1'b1, 32'h600, 1'b0);
        step(1'b1, 32'h601, 1'b0);
        check("post_reset_first_out", 64'(flit_out), 64'({1'b1, 32'h600}));
        for (int i = 2; i < 6; i++) step(1'b1, 32'h600 + i, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        check("post_reset_occupancy", 64'(occupancy), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
